// File: rtl/dlx_adder_pkg.sv
// rtl/dlx_adder_pkg.sv - shared constants and types for the DLX adder arbiter
package dlx_adder_pkg;

  localparam int DLX_WORD_W   = 32;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/adder_rr_grant.sv
// rtl/adder_rr_grant.sv - pointer-rotated priority encoder: first valid index at or after ptr
module adder_rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int          j;
  logic [IDW-1:0] cand;

  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = IDW'(j);
      if (en && valid[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one 32-bit adder with a one-entry response register
// Optional subtract support is enabled by defining ADDER_ARB_SUB_EN.
module adder_arbiter
  import dlx_adder_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [DLX_WORD_W*NREQ-1:0] req_a,
  input  logic [DLX_WORD_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]            req_cin,
`ifdef ADDER_ARB_SUB_EN
  input  logic [NREQ-1:0]            req_sub,
`endif
  output logic [DLX_WORD_W-1:0]      add_a,
  output logic [DLX_WORD_W-1:0]      add_b,
  output logic                       add_cin,
  input  logic [DLX_WORD_W-1:0]      add_s,
  input  logic                       add_cout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DLX_WORD_W-1:0]      rsp_s,
  output logic                       rsp_cout,
  output logic [IDW-1:0]             rsp_id
);

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           slot_avail;

  // Gating with rst_n keeps grants off for the whole time reset is held.
  assign slot_avail = rst_n && ((state == ST_EMPTY) || rsp_ready);
  assign rsp_valid  = (state == ST_FULL);

  adder_rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_grant (
    .valid (req_valid),
    .ptr   (ptr),
    .en    (slot_avail),
    .grant (req_ready),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        add_a = req_a[DLX_WORD_W*i +: DLX_WORD_W];
`ifdef ADDER_ARB_SUB_EN
        if (req_sub[i]) begin
          add_b   = ~req_b[DLX_WORD_W*i +: DLX_WORD_W];
          add_cin = 1'b1;
        end else begin
          add_b   = req_b[DLX_WORD_W*i +: DLX_WORD_W];
          add_cin = req_cin[i];
        end
`else
        add_b   = req_b[DLX_WORD_W*i +: DLX_WORD_W];
        add_cin = req_cin[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      ptr      <= '0;
      rsp_s    <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else if (gnt_any) begin
      state    <= ST_FULL;
      rsp_s    <= add_s;
      rsp_cout <= add_cout;
      rsp_id   <= gnt_idx;
      ptr      <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (state == ST_FULL && rsp_ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
`ifdef ADDER_ARB_SUB_EN
  logic [NREQ-1:0]   req_sub;
`endif
  logic [31:0]       add_a, add_b, add_s;
  logic              add_cin, add_cout;
  logic              rsp_valid, rsp_ready, rsp_cout;
  logic [31:0]       rsp_s;
  logic [IDW-1:0]    rsp_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared carry-select adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADDER_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_s     (rsp_s),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = cin;
    req_valid[i]      = 1'b1;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
`ifdef ADDER_ARB_SUB_EN
    req_sub   = '0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_s !== 32'd0) begin n_fail++; $display("FAIL reset_s: got %h expected 0", rsp_s); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", rsp_id); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    n_checks++; if (add_a !== 32'd0 || add_cin !== 1'b0) begin n_fail++; $display("FAIL reset_adder_in: got a=%h cin=%b expected 0/0", add_a, add_cin); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_reqs();
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 32'd5, 32'd7, 1'b0);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
    n_checks++; if (add_a !== 32'd5 || add_b !== 32'd7) begin n_fail++; $display("FAIL single_operands: got %h/%h expected 5/7", add_a, add_b); end
    @(posedge clk); #1;
    clear_reqs();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_s !== 32'd12 || rsp_cout !== 1'b0 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL single_rsp: got v=%b s=%h c=%b id=%0d expected 1/0000000c/0/1", rsp_valid, rsp_s, rsp_cout, rsp_id);
    end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int         exp_i [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'h10, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (req_ready !== exp_g[c]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, exp_g[c]); end
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_i[c]) || rsp_s !== 32'(exp_i[c] + 16)) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d s=%h expected 1/%0d/%h", c, rsp_valid, rsp_id, rsp_s, exp_i[c], exp_i[c] + 16);
      end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 32'd10, 32'd20, 1'b0);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first_grant: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    clear_reqs();
    set_req(2, 32'd1, 32'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", c, req_ready); end
      n_checks++; if (rsp_valid !== 1'b1 || rsp_s !== 32'd30 || rsp_id !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b s=%h id=%0d expected 1/0000001e/0", c, rsp_valid, rsp_s, rsp_id);
      end
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_refill_grant: got %b expected 0100", req_ready); end
    @(posedge clk); #1;
    clear_reqs();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_s !== 32'd3 || rsp_id !== 2'd2) begin
      n_fail++; $display("FAIL bp_refill_rsp: got v=%b s=%h id=%0d expected 1/00000003/2", rsp_valid, rsp_s, rsp_id);
    end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_carry();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(3, 32'hFFFF_FFFF, 32'h1, 1'b0);
    @(posedge clk); #1;
    clear_reqs();
    n_checks++; if (rsp_s !== 32'h0 || rsp_cout !== 1'b1 || rsp_id !== 2'd3) begin
      n_fail++; $display("FAIL carry_wrap: got s=%h c=%b id=%0d expected 00000000/1/3", rsp_s, rsp_cout, rsp_id);
    end
    @(negedge clk);
    set_req(1, 32'h0, 32'h0, 1'b1);
    @(posedge clk); #1;
    clear_reqs();
    n_checks++; if (rsp_s !== 32'h1 || rsp_cout !== 1'b0 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL carry_cin: got s=%h c=%b id=%0d expected 00000001/0/1", rsp_s, rsp_cout, rsp_id);
    end
  endtask

`ifdef ADDER_ARB_SUB_EN
  task automatic test_sub();
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req(0, 32'd3, 32'd5, 1'b0);
    req_sub[0] = 1'b1;
    @(posedge clk); #1;
    clear_reqs();
    n_checks++; if (rsp_s !== 32'hFFFF_FFFE || rsp_cout !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow: got s=%h c=%b expected fffffffe/0", rsp_s, rsp_cout);
    end
    @(negedge clk);
    set_req(2, 32'd5, 32'd3, 1'b0);
    req_sub[2] = 1'b1;
    @(posedge clk); #1;
    clear_reqs();
    n_checks++; if (rsp_s !== 32'd2 || rsp_cout !== 1'b1) begin
      n_fail++; $display("FAIL sub_noborrow: got s=%h c=%b expected 00000002/1", rsp_s, rsp_cout);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    rsp_ready = 1'b0;
    set_req(2, 32'd40, 32'd2, 1'b0);
    @(posedge clk); #1;
    clear_reqs();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_s !== 32'd42) begin
      n_fail++; $display("FAIL mid_setup: got v=%b id=%0d s=%h expected 1/2/0000002a", rsp_valid, rsp_id, rsp_s);
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 32'd100, 32'(i), 1'b0);
    rsp_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0 || rsp_s !== 32'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL mid_async_clear: got v=%b s=%h id=%0d rdy=%b expected 0/0/0/0000", rsp_valid, rsp_s, rsp_id, req_ready);
    end
    @(posedge clk); #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_accept: got %b expected 0", rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_zero: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    clear_reqs();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_s !== 32'd100) begin
      n_fail++; $display("FAIL mid_first_rsp: got v=%b id=%0d s=%h expected 1/0/00000064", rsp_valid, rsp_id, rsp_s);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_carry();
`ifdef ADDER_ARB_SUB_EN
    test_sub();
`endif
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
